// File: rtl/csr_access_ctrl.sv
// Sequences a single CSR read/modify/write in writeback over a req/ack bus to the CSR file.
// Returns the old CSR value for rd, or an illegal-instruction trap.
module csr_access_ctrl #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_read_en,
  input  logic              in_write_en,
  input  logic [1:0]        in_write_func,
  input  logic              in_input_sel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_rs1_value,
  input  logic [4:0]        in_uimm,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_rd_req,
  input  logic              csr_rd_ack,
  input  logic [XLEN-1:0]   csr_rd_data,
  output logic              csr_wr_req,
  output logic [XLEN-1:0]   csr_wr_data,
  input  logic              csr_wr_ack,
  input  logic              csr_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd_value,
  output logic              out_rd_we,
  output logic              out_exception
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 2);
  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_RS   = 2'd2;
  localparam logic [1:0] F_RC   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  function automatic logic [XLEN-1:0] f_modify(input logic [1:0] func,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] opnd);
    case (func)
      F_RS:    return old | opnd;
      F_RC:    return old & ~opnd;
      default: return opnd;
    endcase
  endfunction

  state_t            r_state;
  logic              r_write_en;
  logic [1:0]        r_func;
  logic [XLEN-1:0]   r_operand;
  logic [XLEN-1:0]   r_old;
  logic              r_read_done;
  logic [CNT_W-1:0]  r_cnt;

  logic [XLEN-1:0]   w_operand;
  logic              w_accept;
  logic              w_ignore;
  logic              w_ro_trap;
  logic              w_timeout;

  assign w_operand = in_input_sel ? {{(XLEN-5){1'b0}}, in_uimm} : in_rs1_value;
  assign w_accept  = in_valid & in_ready;
  assign w_ignore  = (in_write_func == F_NONE) | (~in_read_en & ~in_write_en);
  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  assign w_ro_trap = in_write_en & (in_addr[ADDR_W-1 -: 2] == 2'b11);
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Operation sequencer with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_write_en    <= 1'b0;
      r_func        <= 2'd0;
      r_operand     <= '0;
      r_old         <= '0;
      r_read_done   <= 1'b0;
      r_cnt         <= '0;
      in_ready      <= 1'b1;
      csr_addr      <= '0;
      csr_rd_req    <= 1'b0;
      csr_wr_req    <= 1'b0;
      csr_wr_data   <= '0;
      out_valid     <= 1'b0;
      out_rd_value  <= '0;
      out_rd_we     <= 1'b0;
      out_exception <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_ignore) begin
            in_ready    <= 1'b0;
            csr_addr    <= in_addr;
            r_write_en  <= in_write_en;
            r_func      <= in_write_func;
            r_operand   <= w_operand;
            r_old       <= '0;
            r_read_done <= 1'b0;
            r_cnt       <= '0;
            if (w_ro_trap) begin
              r_state       <= S_RESP;
              out_valid     <= 1'b1;
              out_exception <= 1'b1;
              out_rd_we     <= 1'b0;
              out_rd_value  <= '0;
            end else if (in_read_en) begin
              r_state    <= S_READ;
              csr_rd_req <= 1'b1;
            end else begin
              r_state     <= S_WRITE;
              csr_wr_req  <= 1'b1;
              csr_wr_data <= w_operand;
            end
          end
        end
        S_READ: begin
          if (csr_rd_ack) begin
            csr_rd_req <= 1'b0;
            r_cnt      <= '0;
            if (csr_illegal) begin
              r_state       <= S_RESP;
              out_valid     <= 1'b1;
              out_exception <= 1'b1;
              out_rd_we     <= 1'b0;
              out_rd_value  <= '0;
            end else if (r_write_en) begin
              r_state     <= S_WRITE;
              r_old       <= csr_rd_data;
              r_read_done <= 1'b1;
              csr_wr_req  <= 1'b1;
              csr_wr_data <= f_modify(r_func, csr_rd_data, r_operand);
            end else begin
              r_state       <= S_RESP;
              out_valid     <= 1'b1;
              out_exception <= 1'b0;
              out_rd_we     <= 1'b1;
              out_rd_value  <= csr_rd_data;
            end
          end else if (w_timeout) begin
            csr_rd_req    <= 1'b0;
            r_state       <= S_RESP;
            out_valid     <= 1'b1;
            out_exception <= 1'b1;
            out_rd_we     <= 1'b0;
            out_rd_value  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (csr_wr_ack) begin
            csr_wr_req    <= 1'b0;
            r_state       <= S_RESP;
            out_valid     <= 1'b1;
            out_exception <= csr_illegal;
            out_rd_we     <= r_read_done & ~csr_illegal;
            out_rd_value  <= csr_illegal ? '0 : r_old;
          end else if (w_timeout) begin
            csr_wr_req    <= 1'b0;
            r_state       <= S_RESP;
            out_valid     <= 1'b1;
            out_exception <= 1'b1;
            out_rd_we     <= 1'b0;
            out_rd_value  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_state       <= S_IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_rd_we     <= 1'b0;
            out_exception <= 1'b0;
            out_rd_value  <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          in_ready   <= 1'b1;
          csr_rd_req <= 1'b0;
          csr_wr_req <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl; a behavioural CSR-file responder answers the req/ack bus.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_read_en, in_write_en, in_input_sel;
  logic [1:0]  in_write_func;
  logic [11:0] in_addr;
  logic [31:0] in_rs1_value;
  logic [4:0]  in_uimm;
  logic [11:0] csr_addr;
  logic        csr_rd_req, csr_rd_ack, csr_wr_req, csr_wr_ack, csr_illegal;
  logic [31:0] csr_rd_data, csr_wr_data;
  logic        out_valid, out_ready, out_rd_we, out_exception;
  logic [31:0] out_rd_value;

  int total = 0;
  int bad   = 0;

  int          rd_delay = 0;
  int          wr_delay = 0;
  logic        rd_noack = 1'b0;
  logic        wr_noack = 1'b0;
  logic        ill_rd   = 1'b0;
  logic        ill_wr   = 1'b0;
  logic [31:0] old_val  = 32'h0;
  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] seen_wr;

  csr_access_ctrl #(.XLEN(32), .ADDR_W(12), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_read_en(in_read_en), .in_write_en(in_write_en),
    .in_write_func(in_write_func), .in_input_sel(in_input_sel),
    .in_addr(in_addr), .in_rs1_value(in_rs1_value), .in_uimm(in_uimm),
    .csr_addr(csr_addr), .csr_rd_req(csr_rd_req), .csr_rd_ack(csr_rd_ack),
    .csr_rd_data(csr_rd_data), .csr_wr_req(csr_wr_req), .csr_wr_data(csr_wr_data),
    .csr_wr_ack(csr_wr_ack), .csr_illegal(csr_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_value(out_rd_value),
    .out_rd_we(out_rd_we), .out_exception(out_exception)
  );

  always #5 clk = ~clk;

  // CSR file model: acks a request after a configurable number of waiting cycles.
  initial begin
    int rd_wait;
    int wr_wait;
    rd_wait = 0; wr_wait = 0;
    csr_rd_ack = 1'b0; csr_wr_ack = 1'b0; csr_illegal = 1'b0;
    csr_rd_data = 32'h0; rd_cnt = 0; wr_cnt = 0; seen_wr = 32'h0;
    forever begin
      @(posedge clk); #2;
      csr_rd_ack = 1'b0; csr_wr_ack = 1'b0; csr_illegal = 1'b0;
      if (csr_rd_req) begin
        if (!rd_noack && rd_wait >= rd_delay) begin
          csr_rd_ack = 1'b1; csr_rd_data = old_val; csr_illegal = ill_rd;
          rd_cnt++; rd_wait = 0;
        end else rd_wait++;
      end else rd_wait = 0;
      if (csr_wr_req) begin
        if (!wr_noack && wr_wait >= wr_delay) begin
          csr_wr_ack = 1'b1; csr_illegal = csr_illegal | ill_wr;
          seen_wr = csr_wr_data; wr_cnt++; wr_wait = 0;
        end else wr_wait++;
      end else wr_wait = 0;
    end
  end

  task automatic issue(input logic re, input logic we, input logic [1:0] fn, input logic sel,
                       input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] ui);
    in_valid = 1'b1; in_read_en = re; in_write_en = we; in_write_func = fn;
    in_input_sel = sel; in_addr = a; in_rs1_value = rs1; in_uimm = ui;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, csr_rd_req, csr_wr_req, out_valid, out_rd_we, out_exception} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 100000",
               {in_ready, csr_rd_req, csr_wr_req, out_valid, out_rd_we, out_exception});
    end
    total++;
    if ({csr_addr, csr_wr_data, out_rd_value} !== 76'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wd=%h rv=%h want 0", csr_addr, csr_wr_data, out_rd_value);
    end
  endtask

  task automatic test_rmw(input string nm, input logic [1:0] fn, input logic sel, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] ui, input logic [31:0] old,
                          input logic [31:0] exp_wr);
    int lat; int wr0;
    wr0 = wr_cnt; old_val = old;
    issue(1'b1, 1'b1, fn, sel, a, rs1, ui);
    total++;
    if (csr_rd_req !== 1'b1 || csr_addr !== a) begin
      bad++; $display("FAIL %s_req: got rd_req=%b addr=%h want 1 %h", nm, csr_rd_req, csr_addr, a);
    end
    wait_resp(1, lat);
    total++;
    if (out_valid !== 1'b1 || lat != 3) begin
      bad++; $display("FAIL %s_lat: got valid=%b lat=%0d want 1 3", nm, out_valid, lat);
    end
    total++;
    if (seen_wr !== exp_wr || wr_cnt - wr0 != 1) begin
      bad++; $display("FAIL %s_wdata: got %h (n=%0d) want %h (n=1)", nm, seen_wr, wr_cnt - wr0, exp_wr);
    end
    total++;
    if ({out_rd_we, out_exception, out_rd_value} !== {1'b1, 1'b0, old}) begin
      bad++; $display("FAIL %s_resp: got we=%b exc=%b rv=%h want 1 0 %h",
                      nm, out_rd_we, out_exception, out_rd_value, old);
    end
    drain();
  endtask

  task automatic test_write_only();
    int lat; int rd0; int wr0;
    rd0 = rd_cnt; wr0 = wr_cnt; old_val = 32'h9999;
    issue(1'b0, 1'b1, 2'd1, 1'b0, 12'h341, 32'h0000_4000, 5'd0);
    total++;
    if (csr_rd_req !== 1'b0 || csr_wr_req !== 1'b1 || csr_wr_data !== 32'h0000_4000) begin
      bad++; $display("FAIL wo_req: got rd=%b wr=%b wd=%h want 0 1 00004000", csr_rd_req, csr_wr_req, csr_wr_data);
    end
    wait_resp(1, lat);
    total++;
    if (out_valid !== 1'b1 || lat != 2 || rd_cnt != rd0 || wr_cnt - wr0 != 1) begin
      bad++; $display("FAIL wo_lat: got valid=%b lat=%0d rds=%0d wrs=%0d want 1 2 0 1",
                      out_valid, lat, rd_cnt - rd0, wr_cnt - wr0);
    end
    total++;
    if ({out_rd_we, out_exception, out_rd_value} !== 34'h0) begin
      bad++; $display("FAIL wo_resp: got we=%b exc=%b rv=%h want 0 0 0", out_rd_we, out_exception, out_rd_value);
    end
    drain();
  endtask

  task automatic test_read_only();
    int lat; int wr0;
    wr0 = wr_cnt; old_val = 32'h0000_0ABC;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 12'h342, 32'h0, 5'd0);
    wait_resp(1, lat);
    total++;
    if (out_valid !== 1'b1 || lat != 2 || wr_cnt != wr0) begin
      bad++; $display("FAIL ro_lat: got valid=%b lat=%0d wrs=%0d want 1 2 0", out_valid, lat, wr_cnt - wr0);
    end
    total++;
    if ({out_rd_we, out_exception, out_rd_value} !== {1'b1, 1'b0, 32'h0000_0ABC}) begin
      bad++; $display("FAIL ro_resp: got we=%b exc=%b rv=%h want 1 0 00000abc", out_rd_we, out_exception, out_rd_value);
    end
    drain();
  endtask

  task automatic test_ro_trap();
    int lat; int rd0; int wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 1'b1, 2'd1, 1'b0, 12'hC00, 32'h1, 5'd0);
    wait_resp(1, lat);
    total++;
    if (out_valid !== 1'b1 || lat != 1 || csr_rd_req !== 1'b0 || csr_wr_req !== 1'b0) begin
      bad++; $display("FAIL trap_lat: got valid=%b lat=%0d rd=%b wr=%b want 1 1 0 0", out_valid, lat, csr_rd_req, csr_wr_req);
    end
    total++;
    if (out_exception !== 1'b1 || out_rd_we !== 1'b0 || rd_cnt != rd0 || wr_cnt != wr0) begin
      bad++; $display("FAIL trap_resp: got exc=%b we=%b rds=%0d wrs=%0d want 1 0 0 0",
                      out_exception, out_rd_we, rd_cnt - rd0, wr_cnt - wr0);
    end
    drain();
  endtask

  task automatic test_illegal(input logic on_rd);
    int lat; int wr0;
    wr0 = wr_cnt; old_val = 32'h55; ill_rd = on_rd; ill_wr = ~on_rd;
    issue(1'b1, 1'b1, 2'd1, 1'b0, 12'h7C0, 32'h77, 5'd0);
    wait_resp(1, lat);
    ill_rd = 1'b0; ill_wr = 1'b0;
    total++;
    if (out_valid !== 1'b1 || lat != (on_rd ? 2 : 3) || wr_cnt - wr0 != (on_rd ? 0 : 1)) begin
      bad++; $display("FAIL ill%0d_lat: got valid=%b lat=%0d wrs=%0d", on_rd, out_valid, lat, wr_cnt - wr0);
    end
    total++;
    if ({out_exception, out_rd_we, out_rd_value} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL ill%0d_resp: got exc=%b we=%b rv=%h want 1 0 0", on_rd, out_exception, out_rd_we, out_rd_value);
    end
    drain();
  endtask

  task automatic test_ignored();
    int rd0; int wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 1'b1, 2'd0, 1'b0, 12'h340, 32'h1, 5'd0);
    issue(1'b0, 1'b0, 2'd1, 1'b0, 12'h340, 32'h1, 5'd0);
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || csr_rd_req !== 1'b0 || csr_wr_req !== 1'b0 ||
        rd_cnt != rd0 || wr_cnt != wr0) begin
      bad++; $display("FAIL ignored: got rdy=%b valid=%b rd=%b wr=%b want 1 0 0 0", in_ready, out_valid, csr_rd_req, csr_wr_req);
    end
  endtask

  task automatic test_stall();
    int lat; int unstable;
    logic [31:0] rv_hold;
    unstable = 0; rd_delay = 5; old_val = 32'h1800;
    issue(1'b1, 1'b1, 2'd2, 1'b0, 12'h300, 32'h8, 5'd0);
    in_rs1_value = 32'hFFFF_FFFF; in_addr = 12'h111;
    for (int i = 0; i < 5; i++) begin
      if (csr_rd_req !== 1'b1 || in_ready !== 1'b0 || csr_addr !== 12'h300 || out_valid !== 1'b0) unstable++;
      @(posedge clk); #1;
    end
    rd_delay = 0;
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL stall_req: got %0d unstable cycles want 0", unstable);
    end
    wait_resp(6, lat);
    total++;
    if (out_valid !== 1'b1 || lat != 8 || seen_wr !== 32'h1808) begin
      bad++; $display("FAIL stall_lat: got valid=%b lat=%0d wd=%h want 1 8 00001808", out_valid, lat, seen_wr);
    end
    rv_hold = out_rd_value;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rd_value !== rv_hold || csr_wr_req !== 1'b0) unstable++;
    end
    total++;
    if (unstable != 0 || rv_hold !== 32'h1800 || out_rd_we !== 1'b1) begin
      bad++; $display("FAIL stall_hold: got unstable=%0d rv=%h we=%b want 0 00001800 1", unstable, rv_hold, out_rd_we);
    end
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_rdy: got in_ready=%b during handshake want 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain: got rdy=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_timeout();
    int lat;
    rd_noack = 1'b1;
    issue(1'b1, 1'b1, 2'd1, 1'b0, 12'h343, 32'h3, 5'd0);
    wait_resp(1, lat);
    rd_noack = 1'b0;
    total++;
    if (out_valid !== 1'b1 || lat != 16 || csr_rd_req !== 1'b0) begin
      bad++; $display("FAIL timeout_lat: got valid=%b lat=%0d rd=%b want 1 16 0", out_valid, lat, csr_rd_req);
    end
    total++;
    if ({out_exception, out_rd_we, out_rd_value} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL timeout_resp: got exc=%b we=%b rv=%h want 1 0 0", out_exception, out_rd_we, out_rd_value);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_cnt; wr_noack = 1'b1;
    issue(1'b0, 1'b1, 2'd1, 1'b0, 12'h305, 32'hA5A5_A5A5, 5'd0);
    total++;
    if (csr_wr_req !== 1'b1 || csr_wr_data !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL rstmid_req: got wr=%b wd=%h want 1 a5a5a5a5", csr_wr_req, csr_wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, csr_rd_req, csr_wr_req, out_valid, out_rd_we, out_exception} !== 6'b100000 ||
        {csr_addr, csr_wr_data, out_rd_value} !== 76'h0) begin
      bad++; $display("FAIL rstmid_out: got ctl=%b addr=%h wd=%h want 100000 0 0",
                      {in_ready, csr_rd_req, csr_wr_req, out_valid, out_rd_we, out_exception}, csr_addr, csr_wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_noack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (wr_cnt != wr0 || csr_wr_req !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_after: got wrs=%0d wr=%b rdy=%b want 0 0 1", wr_cnt - wr0, csr_wr_req, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    old_val = 32'h0000_00F0;
    issue(1'b1, 1'b1, 2'd3, 1'b1, 12'h304, 32'hFFFF_FFFF, 5'h10);
    wait_resp(1, lat);
    total++;
    if (lat != 3 || seen_wr !== 32'h0000_00E0 || out_rd_value !== 32'h0000_00F0) begin
      bad++; $display("FAIL b2b_first: got lat=%0d wd=%h rv=%h want 3 000000e0 000000f0", lat, seen_wr, out_rd_value);
    end
    drain();
    old_val = 32'h0000_0001;
    issue(1'b1, 1'b1, 2'd2, 1'b1, 12'h304, 32'h0, 5'h06);
    wait_resp(1, lat);
    total++;
    if (lat != 3 || seen_wr !== 32'h0000_0007 || out_rd_value !== 32'h0000_0001 || out_rd_we !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got lat=%0d wd=%h rv=%h we=%b want 3 00000007 00000001 1",
                      lat, seen_wr, out_rd_value, out_rd_we);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_read_en = 1'b0; in_write_en = 1'b0; in_write_func = 2'd0;
    in_input_sel = 1'b0; in_addr = 12'h0; in_rs1_value = 32'h0; in_uimm = 5'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_rmw("rw",   2'd1, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd0,  32'h0000_1234, 32'hDEAD_BEEF);
    test_rmw("rs",   2'd2, 1'b0, 12'h300, 32'h0000_0008, 5'd0,  32'h0000_1800, 32'h0000_1808);
    test_rmw("rc",   2'd3, 1'b0, 12'h300, 32'h0000_0008, 5'd0,  32'h0000_1800, 32'h0000_1800);
    test_rmw("uimm", 2'd2, 1'b1, 12'h344, 32'hFFFF_0000, 5'h1F, 32'h0000_0100, 32'h0000_011F);
    test_write_only();
    test_read_only();
    test_ro_trap();
    test_illegal(1'b1);
    test_illegal(1'b0);
    test_ignored();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
